// File: rtl/pio_pkg.sv
// ============================================================================
//  Module      : pio_pkg
//  Description : Register map and sizing helpers for the debounced PIO block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_pkg;

    localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
    localparam logic [2:0] PIO_ADDR_IRQ_MASK = 3'd1;
    localparam logic [2:0] PIO_ADDR_EDGE_CAP = 3'd2;
    localparam logic [2:0] PIO_ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] PIO_ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] PIO_ADDR_OUT      = 3'd5;

    // Counter must hold 0..DEBOUNCE_CYCLES; never narrower than one bit.
    function automatic int pio_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pio_debounce_bit.sv
// ============================================================================
//  Module      : pio_debounce_bit
//  Description : One input channel: 2-flop synchroniser, debounce counter,
//                stable flop and rise/fall pulses of the stable value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_debounce_bit
    import pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = pio_cnt_width(DEBOUNCE_CYCLES);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;
    logic r_stable_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= RESET_VAL;
            r_sync2    <= RESET_VAL;
            r_stable_q <= RESET_VAL;
        end else begin
            r_sync1    <= i_pin;
            r_sync2    <= r_sync1;
            r_stable_q <= r_stable;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stable <= RESET_VAL;
                end else begin
                    r_stable <= r_sync2;
                end
            end
        end else begin : g_count
            logic [CNT_W-1:0] r_cnt;

            // Any return to the stable level restarts the count, so glitches never land.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt    <= '0;
                    r_stable <= RESET_VAL;
                end else if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt    <= '0;
                    r_stable <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_q;
    assign o_fall   = ~r_stable & r_stable_q;

endmodule

`default_nettype wire

// File: rtl/pio_debounce_irq.sv
// ============================================================================
//  Module      : pio_debounce_irq
//  Description : Avalon-MM PIO slave with debounced inputs, per-bit edge
//                capture, IRQ mask, W1C clear, registered irq and outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_debounce_irq
    import pio_pkg::*;
#(
    parameter int                   IN_WIDTH        = 4,
    parameter int                   OUT_WIDTH       = 8,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter logic [IN_WIDTH-1:0]  IN_RESET_VAL    = '0,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  in_port,
    output logic [OUT_WIDTH-1:0] out_port
);

    logic [IN_WIDTH-1:0]  w_stable;
    logic [IN_WIDTH-1:0]  w_rise;
    logic [IN_WIDTH-1:0]  w_fall;
    logic [IN_WIDTH-1:0]  w_set;
    logic [IN_WIDTH-1:0]  w_clr;
    logic [IN_WIDTH-1:0]  w_wdata_in;
    logic [31:0]          w_rdata;
    logic                 w_unused_wdata;

    logic [IN_WIDTH-1:0]  r_irq_mask;
    logic [IN_WIDTH-1:0]  r_edge_cap;
    logic [IN_WIDTH-1:0]  r_rise_en;
    logic [IN_WIDTH-1:0]  r_fall_en;
    logic [OUT_WIDTH-1:0] r_out;

    generate
        for (genvar i = 0; i < IN_WIDTH; i++) begin : g_ch
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (IN_RESET_VAL[i])
            ) u_bit (
                .clk      (clk),
                .reset    (reset),
                .i_pin    (in_port[i]),
                .o_stable (w_stable[i]),
                .o_rise   (w_rise[i]),
                .o_fall   (w_fall[i])
            );
        end
    endgenerate

    assign w_wdata_in     = writedata[IN_WIDTH-1:0];
    assign w_unused_wdata = &{1'b0, writedata};
    assign w_set          = (w_rise & r_rise_en) | (w_fall & r_fall_en);
    assign w_clr          = (write && address == PIO_ADDR_EDGE_CAP) ? w_wdata_in : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_mask <= '0;
            r_rise_en  <= '0;
            r_fall_en  <= '0;
            r_out      <= OUT_RESET_VAL;
        end else if (write) begin
            case (address)
                PIO_ADDR_IRQ_MASK: r_irq_mask <= w_wdata_in;
                PIO_ADDR_RISE_EN:  r_rise_en  <= w_wdata_in;
                PIO_ADDR_FALL_EN:  r_fall_en  <= w_wdata_in;
                PIO_ADDR_OUT:      r_out      <= writedata[OUT_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Set is OR-ed after the clear so a coincident event is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cap <= '0;
            irq        <= 1'b0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_set;
            irq        <= |(r_edge_cap & r_irq_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            PIO_ADDR_DATA:     w_rdata = 32'(w_stable);
            PIO_ADDR_IRQ_MASK: w_rdata = 32'(r_irq_mask);
            PIO_ADDR_EDGE_CAP: w_rdata = 32'(r_edge_cap);
            PIO_ADDR_RISE_EN:  w_rdata = 32'(r_rise_en);
            PIO_ADDR_FALL_EN:  w_rdata = 32'(r_fall_en);
            PIO_ADDR_OUT:      w_rdata = 32'(r_out);
            default:           w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            readdata <= w_rdata;
        end
    end

    assign out_port = r_out;

endmodule

`default_nettype wire

// File: tb/tb_pio_debounce_irq.sv
// ============================================================================
//  Module      : tb_pio_debounce_irq
//  Description : Scoreboard bench for pio_debounce_irq (DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pio_debounce_irq;
    import pio_pkg::*;

    localparam int K_RD  = 0;
    localparam int K_IRQ = 1;
    localparam int K_OUT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  in_port = '0;
    logic [7:0]  out_port;
    logic        probe = 1'b0;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pio_debounce_irq #(
        .IN_WIDTH        (4),
        .OUT_WIDTH       (8),
        .DEBOUNCE_CYCLES (4),
        .IN_RESET_VAL    (4'h0),
        .OUT_RESET_VAL   (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .in_port   (in_port),
        .out_port  (out_port)
    );

    always #5 clk = ~clk;

    // Monitor: a read or probe seen at an edge is checked 1 ns later.
    logic        mon_rd;
    logic        mon_pr;
    logic [31:0] mon_act;
    exp_t        mon_e;
    always @(posedge clk) begin
        mon_rd = read;
        mon_pr = probe;
        #1;
        if (mon_rd || mon_pr) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: DUT output %h with no expected value", readdata);
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    K_RD:    mon_act = readdata;
                    K_IRQ:   mon_act = {31'b0, irq};
                    default: mon_act = {24'b0, out_port};
                endcase
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", mon_e.tag, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, input logic [31:0] e, input string tag);
        address = a; read = 1'b1;
        sb.push_back('{K_RD, e, tag});
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic do_probe(input int kind, input logic [31:0] e, input string tag);
        probe = 1'b1;
        sb.push_back('{kind, e, tag});
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic direct_chk(input string tag, input logic [31:0] act, input logic [31:0] e);
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, e);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset asserted mid-cycle clears outputs without waiting for a clock
        do_write(PIO_ADDR_OUT, 32'h5A);
        do_read(PIO_ADDR_OUT, 32'h5A, "out_pre_reset");
        #2 reset = 1'b1;
        #1;
        direct_chk("reset_out_port", {24'b0, out_port}, 32'h00);
        direct_chk("reset_irq", {31'b0, irq}, 32'h0);
        direct_chk("reset_readdata", readdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        do_read(PIO_ADDR_DATA, 32'h0, "data_after_reset");

        // 2: 3-cycle pulse is rejected; a held level lands on read 7
        in_port = 4'b0001;
        for (int i = 0; i < 3; i++) do_read(PIO_ADDR_DATA, 32'h0, "glitch_high");
        in_port = 4'b0000;
        for (int i = 0; i < 10; i++) do_read(PIO_ADDR_DATA, 32'h0, "glitch_after");
        in_port = 4'b0001;
        for (int i = 0; i < 10; i++)
            do_read(PIO_ADDR_DATA, (i >= 6) ? 32'h1 : 32'h0, "debounce_latency");
        in_port = 4'b0000;
        repeat (10) @(negedge clk);

        // 3: rise capture, irq one cycle later, W1C clears
        do_write(PIO_ADDR_RISE_EN, 32'h1);
        do_write(PIO_ADDR_IRQ_MASK, 32'h1);
        in_port = 4'b0001;
        repeat (6) @(negedge clk);
        do_probe(K_IRQ, 32'h0, "irq_at_capture");
        do_probe(K_IRQ, 32'h1, "irq_after_capture");
        do_read(PIO_ADDR_EDGE_CAP, 32'h1, "edge_cap_rise");
        do_probe(K_IRQ, 32'h1, "irq_held");
        address = PIO_ADDR_EDGE_CAP; writedata = 32'h1; write = 1'b1; probe = 1'b1;
        sb.push_back('{K_IRQ, 32'h1, "irq_on_clear_edge"});
        @(negedge clk);
        write = 1'b0; probe = 1'b0;
        do_probe(K_IRQ, 32'h0, "irq_after_clear");
        do_read(PIO_ADDR_EDGE_CAP, 32'h0, "edge_cap_cleared");

        // 4: W1C coinciding with a fall event loses to the set
        do_write(PIO_ADDR_RISE_EN, 32'h0);
        in_port = 4'b0011;
        repeat (10) @(negedge clk);
        do_write(PIO_ADDR_FALL_EN, 32'h2);
        in_port = 4'b0001;
        repeat (6) @(negedge clk);
        do_write(PIO_ADDR_EDGE_CAP, 32'h2);
        do_read(PIO_ADDR_EDGE_CAP, 32'h2, "set_wins_over_clear");
        do_write(PIO_ADDR_EDGE_CAP, 32'h2);
        do_read(PIO_ADDR_EDGE_CAP, 32'h0, "edge_cap_bit1_cleared");

        // 5: disabled edges capture nothing; mask gates irq
        do_write(PIO_ADDR_FALL_EN, 32'h0);
        in_port = 4'b1110;
        repeat (10) @(negedge clk);
        in_port = 4'b0000;
        repeat (10) @(negedge clk);
        do_read(PIO_ADDR_EDGE_CAP, 32'h0, "disabled_no_capture");
        do_probe(K_IRQ, 32'h0, "disabled_no_irq");
        do_write(PIO_ADDR_IRQ_MASK, 32'h0);
        do_write(PIO_ADDR_RISE_EN, 32'h4);
        in_port = 4'b0100;
        repeat (10) @(negedge clk);
        do_read(PIO_ADDR_EDGE_CAP, 32'h4, "edge_cap_bit2");
        do_probe(K_IRQ, 32'h0, "masked_irq");
        do_write(PIO_ADDR_IRQ_MASK, 32'h4);
        do_probe(K_IRQ, 32'h1, "unmasked_irq");
        do_read(PIO_ADDR_DATA, 32'h4, "data_bit2");

        // 6: output register, upper bits dropped, unused addresses, read-before-write
        do_write(PIO_ADDR_OUT, 32'hFFFF_FFA5);
        do_probe(K_OUT, 32'hA5, "out_port_a5");
        do_read(PIO_ADDR_OUT, 32'h0000_00A5, "out_readback");
        do_read(3'd6, 32'h0, "addr6_zero");
        do_write(3'd7, 32'hFFFF_FFFF);
        do_read(3'd7, 32'h0, "addr7_zero");
        address = PIO_ADDR_OUT; writedata = 32'h3C; read = 1'b1; write = 1'b1;
        sb.push_back('{K_RD, 32'hA5, "read_before_write"});
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        do_read(PIO_ADDR_OUT, 32'h3C, "out_after_rw");
        do_probe(K_OUT, 32'h3C, "out_port_3c");

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL %s: no DUT response, expected %h", e.tag, e.exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
